// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM loads/stores onto
// an 8-bit single-port RAM, assembling little-endian words and pulsing completion.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_cancel,
    output logic [31:0]           if_inst,
    output logic                  if_done,
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_type,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_done,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr
);

    typedef enum logic [2:0] {
        IDLE,
        IF_READ,
        MEM_READ,
        MEM_WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [2:0]            cnt;
    logic [2:0]            len;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [31:0]           result;
    logic                  ram_wr_q;

    logic [2:0]            cnt_next;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [2:0]            mem_len;
    logic [7:0]            next_wbyte;
    logic [1:0]            cap_idx;
    logic [31:0]           captured;

    assign cnt_next   = cnt + 3'd1;
    assign next_addr  = base + ADDR_WIDTH'(cnt_next);
    assign next_wbyte = wdata[{cnt_next[1:0], 3'b000} +: 8];

    // The RAM is frozen by the same rdy, so a stalled write must never reach it.
    assign ram_wr = ram_wr_q & rdy;

    always_comb begin
        case (mem_type)
            2'b00:   mem_len = 3'd1;
            2'b01:   mem_len = 3'd2;
            default: mem_len = 3'd4;
        endcase
    end

    // ram_din always carries the byte addressed one cycle earlier, i.e. byte cnt-1.
    always_comb begin
        cap_idx  = cnt[1:0] - 2'd1;
        captured = result;
        captured[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            base      <= '0;
            wdata     <= '0;
            result    <= '0;
            ram_wr_q  <= 1'b0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            if_inst   <= '0;
            if_done   <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        base     <= mem_addr;
                        len      <= mem_len;
                        wdata    <= mem_wdata;
                        result   <= '0;
                        cnt      <= '0;
                        ram_addr <= mem_addr;
                        if (mem_wr) begin
                            state    <= MEM_WRITE;
                            ram_wr_q <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end else begin
                            state <= MEM_READ;
                        end
                    end else if (if_req && !if_cancel) begin
                        base     <= if_addr;
                        len      <= 3'd4;
                        wdata    <= '0;
                        result   <= '0;
                        cnt      <= '0;
                        ram_addr <= if_addr;
                        state    <= IF_READ;
                    end
                end

                IF_READ, MEM_READ: begin
                    if (state == IF_READ && if_cancel) begin
                        state    <= IDLE;
                        ram_addr <= '0;
                        result   <= '0;
                        cnt      <= '0;
                    end else begin
                        if (cnt != 3'd0) begin
                            result <= captured;
                        end
                        if (cnt == len) begin
                            state    <= DONE;
                            ram_addr <= '0;
                            cnt      <= '0;
                            if (state == IF_READ) begin
                                if_inst <= captured;
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= captured;
                                mem_done  <= 1'b1;
                            end
                        end else begin
                            cnt      <= cnt_next;
                            ram_addr <= (cnt_next < len) ? next_addr : '0;
                        end
                    end
                end

                MEM_WRITE: begin
                    if (cnt_next == len) begin
                        state    <= DONE;
                        ram_wr_q <= 1'b0;
                        ram_addr <= '0;
                        ram_dout <= '0;
                        cnt      <= '0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt      <= cnt_next;
                        ram_addr <= next_addr;
                        ram_dout <= next_wbyte;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a byte-array reference model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic [31:0] if_inst;
    logic        if_done;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [1:0]  mem_type;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_cancel (if_cancel),
        .if_inst   (if_inst),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_type  (mem_type),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    logic [7:0]  phys_mem [logic [31:0]];
    logic [7:0]  ref_mem  [logic [31:0]];
    logic [31:0] wr_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    bit got;
    bit seen_if;
    vec_t dir_vecs[10];
    logic [31:0] regions[3];

    // Unwritten RAM holds a deterministic address hash so reads are not all zero.
    function automatic logic [7:0] fill_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return fill_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill_byte(a);
    endfunction

    function automatic int size_of(input logic [1:0] t);
        if (t == 2'b00) return 1;
        if (t == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_rd(a + 32'(k));
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        phys_mem[a] = b;
        ref_mem[a]  = b;
    endtask

    // RAM model: registered read, write at the edge ending a ram_wr cycle, frozen by rdy.
    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= phys_rd(ram_addr);
            if (ram_wr) begin
                phys_mem[ram_addr] = ram_dout;
                wr_log.push_back(ram_addr);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Runs one request from an idle controller and checks latency, bus and data.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int          n;
        int          c;
        bit          seen;
        logic [31:0] ad [8];
        logic [7:0]  dq [8];
        logic        wq [8];
        logic        any_wr;
        n = v.is_if ? 4 : size_of(v.typ);
        for (int k = 0; k < 8; k++) begin
            ad[k] = '0;
            dq[k] = '0;
            wq[k] = 1'b0;
        end
        @(negedge clk);
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            mem_req   = 1'b1;
            mem_wr    = v.wr;
            mem_addr  = v.addr;
            mem_type  = v.typ;
            mem_wdata = v.wdata;
        end
        @(posedge clk);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (c <= 8) begin
                ad[c-1] = ram_addr;
                dq[c-1] = ram_dout;
                wq[c-1] = ram_wr;
            end
            seen = if_done | mem_done;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        check_output({tag, " done seen"}, 32'(seen), 32'd1);
        check_output({tag, " latency"}, 32'(c), 32'(v.exp_lat));
        check_output({tag, " done port"}, {30'd0, if_done, mem_done}, v.is_if ? 32'd2 : 32'd1);
        for (int k = 0; k < n; k++) check_output({tag, " ram_addr"}, ad[k], v.addr + 32'(k));
        if (v.wr) begin
            for (int k = 0; k < n; k++) begin
                check_output({tag, " ram_dout"}, 32'(dq[k]), 32'(v.wdata[8*k +: 8]));
                check_output({tag, " ram_wr on"}, 32'(wq[k]), 32'd1);
            end
            check_output({tag, " ram_wr off in done"}, 32'(wq[n]), 32'd0);
            ref_write(v.addr, n, v.wdata);
        end else begin
            check_output({tag, " data"}, v.is_if ? if_inst : mem_rdata, v.exp_data);
            any_wr = 1'b0;
            for (int k = 0; k <= n; k++) any_wr = any_wr | wq[k];
            check_output({tag, " no ram_wr on read"}, 32'(any_wr), 32'd0);
        end
        @(negedge clk);
        check_output({tag, " idle done"}, {30'd0, if_done, mem_done}, 32'd0);
        check_output({tag, " idle ram_addr"}, ram_addr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        rdy       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_cancel = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_type  = '0;
        mem_wdata = '0;

        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h102, 8'h10);
        preload(32'h103, 8'h00);
        preload(32'h3FF, 8'hFE);
        preload(32'h400, 8'h80);
        preload(32'hFFFF_FFFE, 8'h11);
        preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0000_0000, 8'h33);
        preload(32'h0000_0001, 8'h44);

        dir_vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 2'b10, 32'h0,         6, 32'h0010_0513};
        dir_vecs[1] = '{1'b0, 1'b0, 32'h0000_03FF, 2'b01, 32'h0,         4, 32'h0000_80FE};
        dir_vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0,         6, 32'h4433_2211};
        dir_vecs[3] = '{1'b0, 1'b1, 32'h0000_2000, 2'b00, 32'h0000_00A5, 2, 32'h0};
        dir_vecs[4] = '{1'b0, 1'b0, 32'h0000_2000, 2'b00, 32'h0,         3, 32'h0000_00A5};
        dir_vecs[5] = '{1'b0, 1'b1, 32'h0000_3000, 2'b10, 32'hDEAD_BEEF, 5, 32'h0};
        dir_vecs[6] = '{1'b0, 1'b0, 32'h0000_3000, 2'b11, 32'h0,         6, 32'hDEAD_BEEF};
        dir_vecs[7] = '{1'b0, 1'b0, 32'h0000_3002, 2'b00, 32'h0,         3, 32'h0000_00AD};
        dir_vecs[8] = '{1'b0, 1'b1, 32'h0000_5001, 2'b01, 32'h1234_ABCD, 3, 32'h0};
        dir_vecs[9] = '{1'b0, 1'b0, 32'h0000_5000, 2'b10, 32'h0,         6, 32'h09AB_CD0A};

        // Reset state
        #12;
        check_output("reset ram_addr", ram_addr, 32'd0);
        check_output("reset if_inst", if_inst, 32'd0);
        check_output("reset mem_rdata", mem_rdata, 32'd0);
        check_output("reset flags", {20'd0, ram_dout, if_done, mem_done, ram_wr, 1'b0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply_stimulus(dir_vecs[i], $sformatf("dir%0d", i));

        // Contention: the store wins, the fetch follows right after DONE
        @(negedge clk);
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = 32'h2000;
        mem_type  = 2'b00;
        mem_wdata = 32'h0000_005C;
        if_req    = 1'b1;
        if_addr   = 32'h100;
        @(posedge clk);
        @(negedge clk);
        check_output("contend ram_wr", 32'(ram_wr), 32'd1);
        check_output("contend ram_addr", ram_addr, 32'h2000);
        check_output("contend ram_dout", 32'(ram_dout), 32'h5C);
        @(negedge clk);
        check_output("contend done port", {30'd0, if_done, mem_done}, 32'd1);
        mem_req = 1'b0;
        ref_write(32'h2000, 1, 32'h5C);
        @(negedge clk);
        check_output("contend idle gap", ram_addr, 32'd0);
        @(negedge clk);
        check_output("contend fetch addr", ram_addr, 32'h100);
        cyc = 4;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = if_done;
        end
        if_req = 1'b0;
        check_output("contend fetch cycle", 32'(cyc), 32'd9);
        check_output("contend fetch data", if_inst, ref_read(32'h100, 4));
        check_output("contend ram byte", 32'(phys_rd(32'h2000)), 32'h5C);
        @(negedge clk);

        // Cancel in the second IF_READ cycle, then an immediate load
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(posedge clk);
        @(posedge clk);
        #1;
        if_cancel = 1'b1;
        if_req    = 1'b0;
        mem_req   = 1'b1;
        mem_wr    = 1'b0;
        mem_addr  = 32'h100;
        mem_type  = 2'b00;
        @(negedge clk);
        check_output("cancel second addr", ram_addr, 32'h101);
        @(negedge clk);
        check_output("cancel idle addr", ram_addr, 32'd0);
        seen_if = if_done;
        if_cancel = 1'b0;
        @(negedge clk);
        check_output("cancel load addr", ram_addr, 32'h100);
        cyc = 4;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (if_done) seen_if = 1'b1;
            got = mem_done;
        end
        mem_req = 1'b0;
        check_output("cancel load cycle", 32'(cyc), 32'd6);
        check_output("cancel load data", mem_rdata, 32'h0000_0013);
        check_output("cancel no if_done", 32'(seen_if), 32'd0);
        @(negedge clk);

        // Cancel sampled with if_req in IDLE suppresses acceptance
        @(negedge clk);
        if_req    = 1'b1;
        if_cancel = 1'b1;
        if_addr   = 32'h100;
        @(negedge clk);
        if_req    = 1'b0;
        if_cancel = 1'b0;
        check_output("idle cancel addr", ram_addr, 32'd0);
        @(negedge clk);
        check_output("idle cancel later addr", ram_addr, 32'd0);

        // Three-cycle rdy stall in the middle of a word store
        wr_log.delete();
        @(negedge clk);
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = 32'h6000;
        mem_type  = 2'b10;
        mem_wdata = 32'h1122_3344;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 3 && cyc <= 5) check_output("stall ram_wr", 32'(ram_wr), 32'd0);
            if (cyc == 4) check_output("stall hold addr", ram_addr, 32'h6001);
            got = mem_done;
            rdy = !(cyc >= 2 && cyc <= 4);
        end
        mem_req = 1'b0;
        rdy     = 1'b1;
        check_output("stall done cycle", 32'(cyc), 32'd8);
        check_output("stall write count", 32'(wr_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++)
            check_output("stall write order", wr_log[k], 32'h6000 + 32'(k));
        ref_write(32'h6000, 4, 32'h1122_3344);
        check_output("stall ram contents",
                     {phys_rd(32'h6003), phys_rd(32'h6002), phys_rd(32'h6001), phys_rd(32'h6000)},
                     ref_read(32'h6000, 4));
        @(negedge clk);

        // Randomized traffic against the reference model
        regions[0] = 32'h0000_2000;
        regions[1] = 32'h0000_7000;
        regions[2] = 32'hFFFF_FFF8;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int   n;
            v.is_if  = ($urandom_range(0, 2) == 0);
            v.wr     = v.is_if ? 1'b0 : 1'($urandom_range(0, 1));
            v.addr   = regions[$urandom_range(0, 2)] + 32'($urandom_range(0, 15));
            v.typ    = 2'($urandom_range(0, 3));
            v.wdata  = $urandom;
            n        = v.is_if ? 4 : size_of(v.typ);
            v.exp_lat  = v.wr ? n + 1 : n + 2;
            v.exp_data = v.wr ? 32'h0 : ref_read(v.addr, n);
            apply_stimulus(v, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of a word fetch
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check_output("pre-reset addr", ram_addr, 32'h102);
        rst = 1'b1;
        #1;
        check_output("async reset ram_addr", ram_addr, 32'd0);
        check_output("async reset if_inst", if_inst, 32'd0);
        check_output("async reset mem_rdata", mem_rdata, 32'd0);
        check_output("async reset flags", {20'd0, ram_dout, if_done, mem_done, ram_wr, 1'b0}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(dir_vecs[0], "post-reset fetch");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
